// File: rtl/ahb3lite_sram_ctrl.sv
// rtl/ahb3lite_sram_ctrl.sv - AHB3-Lite slave front-end for a 1R1W synchronous RAM
// Optional transfer error checking: define AHB_SRAM_ERR_EN.
module ahb3lite_sram_ctrl #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_ABITS  = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  output logic [MEM_ABITS-1:0]    waddr_o,
  output logic [HDATA_SIZE-1:0]   din_o,
  output logic                    we_o,
  output logic [HDATA_SIZE/8-1:0] be_o,
  output logic [MEM_ABITS-1:0]    raddr_o,
  input  logic [HDATA_SIZE-1:0]   dout_i
);

  localparam int BE_W = HDATA_SIZE / 8;
  localparam int BA   = $clog2(BE_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    STALL = 3'd3,
    ERR1  = 3'd4,
    ERR2  = 3'd5
  } state_t;

  state_t               state;
  logic [MEM_ABITS-1:0] addr_q;
  logic                 write_q;

  logic                 accept;
  logic                 xfer_err;
  logic [MEM_ABITS-1:0] word_addr;
  logic [BE_W-1:0]      be_new;
  logic                 unused;

  // Byte lanes covered by a transfer of 2**size bytes starting at lane off
  function automatic logic [BE_W-1:0] gen_be(input logic [2:0] size, input logic [BA-1:0] off);
    int nbytes;
    int start;
    logic [BE_W-1:0] be;
    nbytes = 1 << size;
    start  = int'(off);
    be     = '0;
    for (int i = 0; i < BE_W; i++) begin
      be[i] = (i >= start) && (i < start + nbytes);
    end
    return be;
  endfunction

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign word_addr = HADDR[MEM_ABITS+BA-1:BA];
  assign be_new    = gen_be(HSIZE, HADDR[BA-1:0]);

`ifdef AHB_SRAM_ERR_EN
  // Oversized transfers and addresses beyond the RAM are rejected
  assign xfer_err = (HSIZE > 3'(BA)) || ((HADDR >> (MEM_ABITS + BA)) != '0);
`else
  // No checking: upper address bits simply wrap into the RAM
  assign xfer_err = 1'b0;
`endif

  // Read address goes out in the address phase so dout_i lines up with the data phase
  assign raddr_o = accept ? word_addr : addr_q;
  assign waddr_o = addr_q;
  assign din_o   = HWDATA;
  assign HRDATA  = dout_i;

  assign unused = ^{HBURST, HPROT, HADDR, write_q};

  // Transfer FSM with registered handshake and RAM write controls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      we_o      <= 1'b0;
      be_o      <= '0;
    end else begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      we_o      <= 1'b0;
      be_o      <= '0;
      case (state)
        STALL: begin
          // RAM has now seen the write; the re-issued read returns fresh data
          state <= RD;
        end
        ERR1: begin
          state <= ERR2;
          HRESP <= 1'b1;
        end
        default: begin
          if (accept) begin
            addr_q  <= word_addr;
            write_q <= HWRITE;
            if (xfer_err) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (HWRITE) begin
              state <= WR;
              we_o  <= 1'b1;
              be_o  <= be_new;
            end else if (state == WR && word_addr == addr_q) begin
              // RAM has no write-to-read bypass: wait one cycle for the write to land
              state     <= STALL;
              HREADYOUT <= 1'b0;
            end else begin
              state <= RD;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_ctrl.sv
// tb/tb_ahb3lite_sram_ctrl.sv - directed-vector bench for ahb3lite_sram_ctrl
module tb_ahb3lite_sram_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [9:0]  waddr_o;
  logic [31:0] din_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [9:0]  raddr_o;
  logic [31:0] dout_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];

  always #5 clk_i = ~clk_i;

  assign HREADY = HREADYOUT;

  ahb3lite_sram_ctrl #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_ABITS(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .waddr_o(waddr_o), .din_o(din_o), .we_o(we_o), .be_o(be_o), .raddr_o(raddr_o),
    .dout_i(dout_i)
  );

  // 1R1W RAM without bypass: a same-edge read returns the old word
  always @(posedge clk_i) begin
    if (we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (be_o[b]) mem[waddr_o][8*b +: 8] <= din_o[8*b +: 8];
      end
    end
    dout_i <= mem[raddr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic addr_phase(input logic write, input logic [31:0] addr, input logic [2:0] size);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = write;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic idle_phase();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  initial begin
    rst_i  = 1'b1;
    HSEL   = 1'b0;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = 3'd2;
    HBURST = 3'd0;
    HPROT  = 4'd0;
    HTRANS = 2'b00;
    HWDATA = '0;

    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_be", 32'(be_o), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    check("rst_raddr", 32'(raddr_o), 32'd0);

    // word write 0x10
    next_cycle();
    addr_phase(1'b1, 32'h10, 3'd2);
    @(negedge clk_i);
    check("accept_raddr", 32'(raddr_o), 32'd4);

    // data phase of word write, address phase of byte write 0x13
    next_cycle();
    HWDATA = 32'hDEADBEEF;
    addr_phase(1'b1, 32'h13, 3'd0);
    @(negedge clk_i);
    check("word_we", 32'(we_o), 32'd1);
    check("word_waddr", 32'(waddr_o), 32'd4);
    check("word_be", 32'(be_o), 32'hF);
    check("word_din", din_o, 32'hDEADBEEF);
    check("word_hready", 32'(HREADYOUT), 32'd1);

    // data phase of byte write, address phase of write 0x20
    next_cycle();
    HWDATA = 32'hAB000000;
    addr_phase(1'b1, 32'h20, 3'd2);
    @(negedge clk_i);
    check("byte_we", 32'(we_o), 32'd1);
    check("byte_be", 32'(be_o), 32'h8);
    check("byte_waddr", 32'(waddr_o), 32'd4);
    check("byte_din", din_o, 32'hAB000000);

    // data phase of write 0x20, back-to-back read of 0x20
    next_cycle();
    HWDATA = 32'h12345678;
    addr_phase(1'b0, 32'h20, 3'd2);
    @(negedge clk_i);
    check("raw_wr_waddr", 32'(waddr_o), 32'd8);
    check("raw_wr_hready", 32'(HREADYOUT), 32'd1);

    // wait state: master holds the read address phase
    next_cycle();
    @(negedge clk_i);
    check("raw_stall_hready", 32'(HREADYOUT), 32'd0);
    check("raw_stall_we", 32'(we_o), 32'd0);
    check("raw_stall_raddr", 32'(raddr_o), 32'd8);

    // read data phase, address phase of write 0x24
    next_cycle();
    addr_phase(1'b1, 32'h24, 3'd2);
    @(negedge clk_i);
    check("raw_rd_hready", 32'(HREADYOUT), 32'd1);
    check("raw_rd_data", HRDATA, 32'h12345678);

    // data phase write 0x24, address phase write 0x20
    next_cycle();
    HWDATA = 32'hCAFEF00D;
    addr_phase(1'b1, 32'h20, 3'd2);
    @(negedge clk_i);
    check("w24_waddr", 32'(waddr_o), 32'd9);

    // data phase write 0x20, read 0x24 (different word)
    next_cycle();
    HWDATA = 32'h11112222;
    addr_phase(1'b0, 32'h24, 3'd2);
    @(negedge clk_i);
    check("diff_wr_hready", 32'(HREADYOUT), 32'd1);

    // read 0x24 data phase with no wait state, address phase read 0x10
    next_cycle();
    addr_phase(1'b0, 32'h10, 3'd2);
    @(negedge clk_i);
    check("diff_rd_hready", 32'(HREADYOUT), 32'd1);
    check("diff_rd_data", HRDATA, 32'hCAFEF00D);

    // read 0x10 data phase, address phase halfword write 0x12
    next_cycle();
    addr_phase(1'b1, 32'h12, 3'd1);
    @(negedge clk_i);
    check("rd_word4", HRDATA, 32'hABADBEEF);

    // write-after-read: no stall, upper halfword lanes
    next_cycle();
    HWDATA = 32'h5A5A0000;
    idle_phase();
    @(negedge clk_i);
    check("war_hready", 32'(HREADYOUT), 32'd1);
    check("half_be", 32'(be_o), 32'hC);
    check("half_we", 32'(we_o), 32'd1);

    // idle cycle, then read back word 4
    next_cycle();
    addr_phase(1'b0, 32'h10, 3'd2);
    @(negedge clk_i);
    check("idle_we", 32'(we_o), 32'd0);

    next_cycle();
    addr_phase(1'b1, 32'h30, 3'd2);
    @(negedge clk_i);
    check("rd_half_merge", HRDATA, 32'h5A5ABEEF);

    // reset in the middle of a write data phase
    next_cycle();
    HWDATA = 32'h77777777;
    idle_phase();
    @(negedge clk_i);
    check("pre_rst_we", 32'(we_o), 32'd1);
    check("pre_rst_waddr", 32'(waddr_o), 32'd12);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_we", 32'(we_o), 32'd0);
    check("mid_rst_be", 32'(be_o), 32'd0);
    check("mid_rst_waddr", 32'(waddr_o), 32'd0);
    check("mid_rst_hready", 32'(HREADYOUT), 32'd1);

`ifdef AHB_SRAM_ERR_EN
    // oversized transfer: two-cycle ERROR, no RAM write
    next_cycle();
    addr_phase(1'b1, 32'h40, 3'd3);
    next_cycle();
    idle_phase();
    @(negedge clk_i);
    check("err1_hready", 32'(HREADYOUT), 32'd0);
    check("err1_hresp", 32'(HRESP), 32'd1);
    check("err1_we", 32'(we_o), 32'd0);
    next_cycle();
    @(negedge clk_i);
    check("err2_hready", 32'(HREADYOUT), 32'd1);
    check("err2_hresp", 32'(HRESP), 32'd1);
    check("err2_we", 32'(we_o), 32'd0);
    next_cycle();
    @(negedge clk_i);
    check("err_done_hresp", 32'(HRESP), 32'd0);
`else
    // out-of-range address wraps into the RAM, response stays OKAY
    next_cycle();
    addr_phase(1'b1, 32'h1004, 3'd2);
    next_cycle();
    HWDATA = 32'h0BADF00D;
    idle_phase();
    @(negedge clk_i);
    check("wrap_we", 32'(we_o), 32'd1);
    check("wrap_waddr", 32'(waddr_o), 32'd1);
    check("wrap_hresp", 32'(HRESP), 32'd0);
`endif

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_ctrl.md
Name: ahb3lite_sram_ctrl

Overview:
AHB3-Lite slave front-end that drives a 1R1W synchronous RAM: its write port (waddr/din/we/be) and its read port (raddr, with registered dout one cycle later).
- Converts AHB address/data phases into RAM accesses.
- Generates byte enables from HSIZE and the low HADDR bits.
- Resolves the read-after-write hazard of the RAM, which has no bypass, by inserting one wait state.
- Sits between the AHB interconnect and the RAM instance in the slave subsystem.

Parameters:
HADDR_SIZE, 32, AHB address width
HDATA_SIZE, 32, AHB/RAM data width (32 or 64)
MEM_ABITS, 10, RAM word-address width (depth 2**MEM_ABITS words)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  address
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  burst type (accepted, not decoded)
HPROT  in  4  protection (ignored)
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HWDATA  in  HDATA_SIZE  write data
HREADY  in  1  bus ready (previous transfer complete)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY 1=ERROR
HRDATA  out  HDATA_SIZE  read data
waddr_o  out  MEM_ABITS  RAM write word address
din_o  out  HDATA_SIZE  RAM write data
we_o  out  1  RAM write enable
be_o  out  HDATA_SIZE/8  RAM byte enables
raddr_o  out  MEM_ABITS  RAM read word address
dout_i  in  HDATA_SIZE  RAM read data, valid one cycle after raddr_o

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values:
  - HREADYOUT=1, HRESP=0, we_o=0, be_o=0, waddr_o=0, raddr_o=0.
  - State=IDLE; latched address, latched byte enables and latched direction all 0.
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ). When accepted, latch the following:
  - word address = HADDR[MEM_ABITS+log2(HDATA_SIZE/8)-1 : log2(HDATA_SIZE/8)];
  - HWRITE;
  - byte enables = ((1<<(1<<HSIZE))-1) << HADDR[log2(HDATA_SIZE/8)-1:0].
- IDLE/BUSY, or HSEL=0: no access; next state is IDLE, with HREADYOUT=1 and HRESP=0.
- Read address phase:
  - raddr_o is driven combinationally with the HADDR word address in the accept cycle.
  - Otherwise raddr_o holds the latched read address.
- States:
  - IDLE: no data phase pending. Accept write -> WR. Accept read -> RD.
  - WR (write data phase, 1 cycle):
    - Outputs: we_o=1, waddr_o=latched address, din_o=HWDATA, be_o=latched byte enables, HREADYOUT=1.
    - A new accept in the same cycle pipelines as in IDLE, except for the hazard below.
  - Hazard: in WR, an accepted read whose word address equals the latched write address -> STALL.
  - RD (read data phase): HRDATA=dout_i, HREADYOUT=1. Zero wait states. Next state is decided by the accept condition.
  - STALL:
    - HREADYOUT=0, HRDATA is don't-care, raddr_o=latched read address.
    - Next state is RD, so the read costs exactly one wait state and returns the just-written data.
- Write-after-read and read/write to different addresses: no stall.
- A new accept is impossible while HREADYOUT=0, because HREADY=0.
- Reset asserted mid-transfer: next cycle is at reset values. The pending write is dropped (we_o=0).
- HBURST is ignored; each beat is handled independently.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined:
  - An accepted transfer with HSIZE > log2(HDATA_SIZE/8), or with HADDR bits above the word-address range non-zero, gives a two-cycle ERROR response and no RAM write.
  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Then IDLE or the pipelined accept.
- Undefined: no checking; HRESP is tied to 0 and upper address bits wrap.

Test Plan:
- Reset: rst_i=1 for 2 cycles -> HREADYOUT=1, HRESP=0, we_o=0, be_o=0.
- Word write: NONSEQ write HADDR=0x10, HSIZE=2, HWDATA=0xDEADBEEF -> in the data phase we_o=1, waddr_o=4, be_o=4'b1111, din_o=0xDEADBEEF.
- Byte write: HADDR=0x13, HSIZE=0, HWDATA=0xAB000000 -> be_o=4'b1000, waddr_o=4.
- Read-after-write hazard:
  - Stimulus: write 0x12345678 to 0x20, then a back-to-back read of 0x20.
  - Response: one cycle with HREADYOUT=0, then HRDATA=0x12345678 with HREADYOUT=1.
- Read to a different address: back-to-back write 0x20 / read 0x24 -> no wait state; HRDATA = the RAM content at word 9.
- With AHB_SRAM_ERR_EN defined: HSIZE=3 on HDATA_SIZE=32 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, and we_o stays 0.
